// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizes for the program/data RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned RAM_LAT_DEF = 1;
  // Wide enough for RAM_LAT-1 with RAM_LAT in 1..4
  localparam int unsigned CNT_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-input picker (fetch=0, data=1) with a last-owner register.
// MEM_ARB_FIXED_PRIO_EN: when defined, data always wins and no history is kept.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output owner_e     gnt_sel_c_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk, rst, take_i, req_i[0]};

  // Data has strict priority; fetch only when data is not requesting
  always_comb begin
    gnt_sel_c_o = req_i[1] ? OWN_DATA : OWN_FETCH;
  end
`else
  owner_e last_q;
  owner_e last_d;

  // Last-owner history, starts as DATA so fetch wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= OWN_DATA;
    end else begin
      last_q <= last_d;
    end
  end

  // Single requester wins; on a tie the one that did not go last wins
  always_comb begin
    gnt_sel_c_o = OWN_FETCH;
    last_d      = last_q;
    case (req_i)
      2'b01:   gnt_sel_c_o = OWN_FETCH;
      2'b10:   gnt_sel_c_o = OWN_DATA;
      2'b11:   gnt_sel_c_o = (last_q == OWN_DATA) ? OWN_FETCH : OWN_DATA;
      default: gnt_sel_c_o = OWN_FETCH;
    endcase
    if (take_i) begin
      last_d = gnt_sel_c_o;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto the single-port RAM,
// waits out RAM_LAT and returns registered read data with a one-cycle valid.
// MEM_ARB_FIXED_PRIO_EN: when defined, data beats fetch on every tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               we_q, we_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fetch_gnt_q, fetch_gnt_d;
  logic               data_gnt_q, data_gnt_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               data_valid_q, data_valid_d;
  logic [DATA_W-1:0]  fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0]  data_rdata_q, data_rdata_d;
  logic               ram_en_q, ram_en_d;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic               busy_q, busy_d;
  logic               take_c;
  owner_e             gnt_sel_c;

  arb_rr2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       ({data_req, fetch_req}),
    .take_i      (take_c),
    .gnt_sel_c_o (gnt_sel_c)
  );

  // State and all output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_DATA;
      we_q          <= 1'b0;
      cnt_q         <= '0;
      fetch_gnt_q   <= 1'b0;
      data_gnt_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      cnt_q         <= cnt_d;
      fetch_gnt_q   <= fetch_gnt_d;
      data_gnt_q    <= data_gnt_d;
      fetch_valid_q <= fetch_valid_d;
      data_valid_q  <= data_valid_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      busy_q        <= busy_d;
    end
  end

  // Next state; pulse outputs are computed one cycle early so they land registered
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    cnt_d         = cnt_q;
    fetch_gnt_d   = 1'b0;
    data_gnt_d    = 1'b0;
    fetch_valid_d = 1'b0;
    data_valid_d  = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    ram_en_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    take_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_req || data_req) begin
          take_c   = 1'b1;
          owner_d  = gnt_sel_c;
          ram_en_d = 1'b1;
          state_d  = ST_ACCESS;
          if (gnt_sel_c == OWN_DATA) begin
            data_gnt_d  = 1'b1;
            we_d        = data_we;
            ram_we_d    = data_we;
            ram_addr_d  = data_addr;
            ram_wdata_d = data_wdata;
          end else begin
            fetch_gnt_d = 1'b1;
            we_d        = 1'b0;
            ram_addr_d  = fetch_addr;
          end
        end
      end
      ST_ACCESS: begin
        cnt_d   = CNT_W'(RAM_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_DATA) begin
            data_valid_d = 1'b1;
            if (!we_q) begin
              data_rdata_d = ram_rdata;
            end
          end else begin
            fetch_valid_d = 1'b1;
            fetch_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign fetch_gnt   = fetch_gnt_q;
  assign data_gnt    = data_gnt_q;
  assign fetch_valid = fetch_valid_q;
  assign data_valid  = data_valid_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign busy        = busy_q;

endmodule
